// File: rtl/rvc_fetch_expander.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rvc_fetch_expander - realigns 32-bit fetch words into whole instructions and,
// when RVC_EXPAND_EN is defined, expands RV32C halves to RV32I.   Rev 1.0
// ----------------------------------------------------------------------------
module rvc_fetch_expander #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_data,
  input  logic [ADDR_W-1:0] in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic              out_compressed,
  output logic              out_illegal
);

  logic [15:0]       res;
  logic [ADDR_W-1:0] res_pc;
  logic              res_valid;

  logic              slot_free, res_c, low_c;
  logic              emit, is_half, res_ld, res_valid_nxt;
  logic [15:0]       half_sel;
  logic [31:0]       word, instr_nxt;
  logic              ill_nxt;
  logic [ADDR_W-1:0] emit_pc, res_pc_nxt;

`ifdef RVC_EXPAND_EN
  // Returns {illegal, instr}; illegal encodings carry the raw half.
  function automatic logic [32:0] expand(input logic [15:0] c);
    logic [31:0] r;
    logic        ill;
    logic [4:0]  rd, rs2, rdp, rs1p;
    logic [11:0] imm6, aimm;
    logic [9:0]  nimm;
    logic [6:0]  limm;
    logic [7:0]  wimm, simm;
    logic [19:0] j;
    logic [11:0] b;
    logic [6:0]  f7;
    logic [2:0]  f3;
    r    = 32'h0;
    ill  = 1'b0;
    rd   = c[11:7];
    rs2  = c[6:2];
    rdp  = {2'b01, c[4:2]};
    rs1p = {2'b01, c[9:7]};
    imm6 = {{6{c[12]}}, c[12], c[6:2]};
    aimm = {{2{c[12]}}, c[12], c[4:3], c[5], c[2], c[6], 4'b0000};
    nimm = {c[10:7], c[12:11], c[5], c[6], 2'b00};
    limm = {c[5], c[12:10], c[6], 2'b00};
    wimm = {c[3:2], c[12], c[6:4], 2'b00};
    simm = {c[8:7], c[12:9], 2'b00};
    j    = {{9{c[12]}}, c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3]};
    b    = {{4{c[12]}}, c[12], c[6:5], c[2], c[11:10], c[4:3]};
    f7   = 7'b0000000;
    f3   = 3'b000;
    case ({c[1:0], c[15:13]})
      5'b00_000: begin
        ill = (nimm == 10'd0);
        r   = {2'b00, nimm, 5'd2, 3'b000, rdp, 7'h13};
      end
      5'b00_010: r = {5'b0, limm, rs1p, 3'b010, rdp, 7'h03};
      5'b00_110: r = {5'b0, limm[6:5], rdp, rs1p, 3'b010, limm[4:0], 7'h23};
      5'b01_000: r = {imm6, rd, 3'b000, rd, 7'h13};
      5'b01_001: r = {j[19], j[9:0], j[10], j[18:11], 5'd1, 7'h6F};
      5'b01_010: r = {imm6, 5'd0, 3'b000, rd, 7'h13};
      5'b01_011: begin
        if (rd == 5'd2) begin
          ill = (aimm == 12'd0);
          r   = {aimm, 5'd2, 3'b000, 5'd2, 7'h13};
        end else begin
          ill = ({c[12], c[6:2]} == 6'd0);
          r   = {{15{c[12]}}, c[6:2], rd, 7'h37};
        end
      end
      5'b01_100: begin
        case (c[11:10])
          2'b00: begin
            ill = c[12];
            r   = {7'b0000000, c[6:2], rs1p, 3'b101, rs1p, 7'h13};
          end
          2'b01: begin
            ill = c[12];
            r   = {7'b0100000, c[6:2], rs1p, 3'b101, rs1p, 7'h13};
          end
          2'b10: r = {imm6, rs1p, 3'b111, rs1p, 7'h13};
          default: begin
            // c[12]=1 selects the RV64-only SUBW/ADDW group
            ill = c[12];
            case (c[6:5])
              2'b00:   begin f7 = 7'b0100000; f3 = 3'b000; end
              2'b01:   f3 = 3'b100;
              2'b10:   f3 = 3'b110;
              default: f3 = 3'b111;
            endcase
            r = {f7, rdp, rs1p, f3, rs1p, 7'h33};
          end
        endcase
      end
      5'b01_101: r = {j[19], j[9:0], j[10], j[18:11], 5'd0, 7'h6F};
      5'b01_110,
      5'b01_111: r = {b[11], b[9:4], 5'd0, rs1p, 2'b00, c[13], b[3:0], b[10], 7'h63};
      5'b10_000: begin
        ill = c[12];
        r   = {7'b0000000, c[6:2], rd, 3'b001, rd, 7'h13};
      end
      5'b10_010: begin
        ill = (rd == 5'd0);
        r   = {4'b0, wimm, 5'd2, 3'b010, rd, 7'h03};
      end
      5'b10_100: begin
        if (!c[12]) begin
          if (rs2 == 5'd0) begin
            ill = (rd == 5'd0);
            r   = {12'h0, rd, 3'b000, 5'd0, 7'h67};
          end else begin
            r = {7'b0, rs2, 5'd0, 3'b000, rd, 7'h33};
          end
        end else if (rs2 == 5'd0) begin
          r = (rd == 5'd0) ? 32'h0010_0073 : {12'h0, rd, 3'b000, 5'd1, 7'h67};
        end else begin
          r = {7'b0, rs2, rd, 3'b000, rd, 7'h33};
        end
      end
      5'b10_110: r = {4'b0, simm[7:5], rs2, 5'd2, 3'b010, simm[4:0], 7'h23};
      default:   ill = 1'b1;
    endcase
    if (c == 16'h0000) ill = 1'b1;
    if (ill) r = {16'h0, c};
    return {ill, r};
  endfunction
`endif

  assign slot_free = !out_valid || out_ready;
  assign res_c     = (res[1:0] != 2'b11);
  assign low_c     = (in_data[1:0] != 2'b11);
  assign in_ready  = rst_n && slot_free && !(res_valid && res_c) && !flush;

  always_comb begin
    emit          = 1'b0;
    is_half       = 1'b0;
    half_sel      = res;
    word          = in_data;
    emit_pc       = res_pc;
    res_ld        = 1'b0;
    res_pc_nxt    = in_pc + ADDR_W'(2);
    res_valid_nxt = res_valid;
    if (res_valid && res_c) begin
      emit          = 1'b1;
      is_half       = 1'b1;
      res_valid_nxt = 1'b0;
    end else if (res_valid) begin
      if (in_valid) begin
        emit   = 1'b1;
        word   = {in_data[15:0], res};
        res_ld = 1'b1;
      end
    end else if (in_valid) begin
      if (in_pc[1]) begin
        res_ld        = 1'b1;
        res_pc_nxt    = in_pc;
        res_valid_nxt = 1'b1;
      end else if (low_c) begin
        emit          = 1'b1;
        is_half       = 1'b1;
        half_sel      = in_data[15:0];
        emit_pc       = in_pc;
        res_ld        = 1'b1;
        res_valid_nxt = 1'b1;
      end else begin
        emit    = 1'b1;
        emit_pc = in_pc;
      end
    end
  end

  always_comb begin
    instr_nxt = word;
    ill_nxt   = 1'b0;
    if (is_half) begin
`ifdef RVC_EXPAND_EN
      {ill_nxt, instr_nxt} = expand(half_sel);
`else
      instr_nxt = {16'h0, half_sel};
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid      <= 1'b0;
      out_instr      <= 32'h0;
      out_pc         <= '0;
      out_compressed <= 1'b0;
      out_illegal    <= 1'b0;
      res            <= 16'h0;
      res_pc         <= '0;
      res_valid      <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
      res_valid <= 1'b0;
    end else if (slot_free) begin
      out_valid <= emit;
      if (emit) begin
        out_instr      <= instr_nxt;
        out_pc         <= emit_pc;
        out_compressed <= is_half;
        out_illegal    <= ill_nxt;
      end
      if (res_ld) begin
        res    <= in_data[31:16];
        res_pc <= res_pc_nxt;
      end
      res_valid <= res_valid_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rvc_fetch_expander.sv
`default_nettype none
// tb_rvc_fetch_expander: scoreboard bench for realignment and (optional) RV32C expansion.
module tb_rvc_fetch_expander;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = 32'h0;
  logic [31:0] in_pc = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_compressed;
  logic        out_illegal;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        comp;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic bp_done = 1'b0;

  rvc_fetch_expander #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .out_compressed(out_compressed), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t e32(input logic [31:0] w, input logic [31:0] pc);
    return '{w, pc, 1'b0, 1'b0};
  endfunction

  function automatic exp_t e16(input logic [15:0] h, input logic [31:0] x, input logic il,
                               input logic [31:0] pc);
`ifdef RVC_EXPAND_EN
    return '{(il ? {16'h0, h} : x), pc, 1'b1, il};
`else
    return '{{16'h0, h}, pc, 1'b1, 1'b0};
`endif
  endfunction

  // Present a word; it is accepted on the first posedge after a negedge that sees in_ready.
  task automatic send(input logic [31:0] d, input logic [31:0] pc);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    in_pc    = pc;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("accept", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      check("sb_nonempty", (sb.size() != 0), 1'b1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("instr", out_instr, e.instr);
        check("pc", out_pc, e.pc);
        check("flags", {out_compressed, out_illegal}, {e.comp, e.ill});
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  logic [15:0] hv [14];
  logic [31:0] xv [14];
  logic        il [14];
  logic [31:0] pc;
  logic [67:0] snap;

  initial begin
    hv = '{16'h4144, 16'h10FD, 16'h852E, 16'h6505, 16'h8082, 16'hC606, 16'h717D,
           16'h8C05, 16'hE401, 16'h1082, 16'h9C05, 16'h9002, 16'h4002, 16'h0000};
    xv = '{32'h00452483, 32'hFFF08093, 32'h00B00533, 32'h00001537, 32'h00008067,
           32'h00112623, 32'hFF010113, 32'h40940433, 32'h00041463, 32'h0,
           32'h0, 32'h00100073, 32'h0, 32'h0};
    il = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
           1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_valid", out_valid, 1'b0);
    check("rst_instr", out_instr, 32'h0);
    check("rst_pc", out_pc, 32'h0);
    check("rst_flags", {out_compressed, out_illegal}, 2'b00);
    check("rst_ready", in_ready, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Plain 32-bit word
    sb.push_back(e32(32'h00000513, 32'h100));
    send(32'h00000513, 32'h100);
    drain();

    // Two compressed halves; no input taken between them
    sb.push_back(e16(16'h4081, 32'h00000093, 1'b0, 32'h100));
    sb.push_back(e16(16'h4501, 32'h00000513, 1'b0, 32'h102));
    send(32'h45014081, 32'h100);
    @(negedge clk);
    check("gap_ready", in_ready, 1'b0);
    drain();

    // Straddling 32-bit instruction
    sb.push_back(e16(16'h4081, 32'h00000093, 1'b0, 32'h100));
    sb.push_back(e32(32'h00000513, 32'h102));
    sb.push_back(e16(16'h4501, 32'h00000513, 1'b0, 32'h106));
    send(32'h05134081, 32'h100);
    send(32'h45010000, 32'h104);
    drain();

    // All-zero halves are illegal
    sb.push_back(e16(16'h0000, 32'h0, 1'b1, 32'h200));
    sb.push_back(e16(16'h0000, 32'h0, 1'b1, 32'h202));
    send(32'h00000000, 32'h200);
    drain();

    // Expansion table, two halves per word
    for (int i = 0; i < 7; i++) begin
      pc = 32'h300 + 32'(i * 4);
      sb.push_back(e16(hv[2*i], xv[2*i], il[2*i], pc));
      sb.push_back(e16(hv[2*i+1], xv[2*i+1], il[2*i+1], pc + 32'd2));
      send({hv[2*i+1], hv[2*i]}, pc);
    end
    drain();

    // PC near the top of the address space
    sb.push_back(e16(16'h4081, 32'h00000093, 1'b0, 32'hFFFF_FFFC));
    sb.push_back(e32(32'h00000513, 32'hFFFF_FFFE));
    sb.push_back(e16(16'h4501, 32'h00000513, 1'b0, 32'h0000_0002));
    send(32'h05134081, 32'hFFFF_FFFC);
    send(32'h45010000, 32'h0000_0000);
    drain();

    // Backpressure: outputs hold, nothing is lost
    out_ready = 1'b0;
    sb.push_back(e16(16'h4081, 32'h00000093, 1'b0, 32'h500));
    sb.push_back(e32(32'h00000513, 32'h502));
    sb.push_back(e16(16'h4501, 32'h00000513, 1'b0, 32'h506));
    fork
      begin
        send(32'h05134081, 32'h500);
        send(32'h45010000, 32'h504);
        bp_done = 1'b1;
      end
    join_none
    @(negedge clk);
    @(negedge clk);
    check("stall_valid", out_valid, 1'b1);
    snap = {out_valid, out_instr, out_pc, out_compressed, out_illegal, in_ready};
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_hold", {out_valid, out_instr, out_pc, out_compressed, out_illegal, in_ready},
            snap);
      check("stall_ready", in_ready, 1'b0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int k = 0; k < 100 && !bp_done; k++) @(posedge clk);
    check("bp_sender_done", bp_done, 1'b1);
    #1;
    drain();

    // Flush mid-straddle: pending output and residue are discarded
    out_ready = 1'b0;
    send(32'h05134081, 32'h600);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'h4501DEAD;
    in_pc    = 32'h202;
    @(negedge clk);
    check("flush_ready", in_ready, 1'b0);
    @(posedge clk);
    #1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("flush_valid", out_valid, 1'b0);
    sb.push_back(e16(16'h4501, 32'h00000513, 1'b0, 32'h202));
    send(32'h4501DEAD, 32'h202);
    drain();

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    send(32'h00000513, 32'h700);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", out_valid, 1'b0);
    check("arst_instr", out_instr, 32'h0);
    check("arst_pc", out_pc, 32'h0);
    check("arst_flags", {out_compressed, out_illegal}, 2'b00);
    check("arst_ready", in_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    sb.push_back(e32(32'h00A00093, 32'h704));
    send(32'h00A00093, 32'h704);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
